cpu_mem_arbiter: RTL and testbench

// - Shares one 32-bit memory port between the instruction-fetch stage and the data (MEM) stage.
// - Sequences each access with a registered request/ready handshake.
// - Drives cpu_stall to freeze the pipeline while any access is outstanding.
// - Sits between the CPU pipeline and the memory/bus interface.

---
 rtl/cpu_mem_arbiter.sv | 175 +++++++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one 32-bit memory port between instruction fetch
// and the data stage with a registered request/ready handshake, a fetch
// starvation guard and a busy timeout.
// Optional stall-cycle counter enabled by defining ARB_PERF_CNT_EN.
module cpu_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        cpu_stall,
  output logic        err,
  output logic [31:0] perf_stall
);

  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  // The abort fires on the busy cycle whose increment would reach TIMEOUT.
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            w_grant_d;
  logic            w_grant_f;
  logic            w_done;
  logic            w_abort;
  logic            w_busy;
  logic [SW-1:0]   r_starve;
  logic [TW-1:0]   r_tmo;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_if_ack;
  logic            r_d_ack;
  logic [31:0]     r_if_rdata;
  logic [31:0]     r_d_rdata;
  logic            r_err;

  assign w_busy    = (r_state != IDLE);
  assign mem_req   = w_busy;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ack    = r_if_ack;
  assign d_ack     = r_d_ack;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign err       = r_err;
  assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Next-state logic: arbitration in IDLE (blocked during the ack cycle), completion/abort when busy.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_f   = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_if_ack && !r_d_ack) begin
          if (d_req && (!if_req || (r_starve != STARVE_LIM))) begin
            w_grant_d   = 1'b1;
            w_state_nxt = DATA;
          end else if (if_req) begin
            w_grant_f   = 1'b1;
            w_state_nxt = FETCH;
          end
        end
      end
      FETCH, DATA: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Starvation and timeout counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
      r_tmo    <= '0;
    end else begin
      if (w_grant_f)
        r_starve <= '0;
      else if (w_grant_d && if_req && (r_starve != STARVE_LIM))
        r_starve <= r_starve + 1'b1;
      if (w_grant_d || w_grant_f)
        r_tmo <= '0;
      else if (w_busy && !mem_ready)
        r_tmo <= r_tmo + 1'b1;
    end
  end

  // Capture the granted requester's access on the grant edge; held for the whole access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_d) begin
      r_we    <= d_we;
      r_addr  <= d_addr;
      r_wdata <= d_wdata;
    end else if (w_grant_f) begin
      r_we    <= 1'b0;
      r_addr  <= if_addr;
      r_wdata <= '0;
    end
  end

  // Completion: one-cycle ack/err pulses and registered read data (zero on abort or write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ack <= (w_done || w_abort) && (r_state == FETCH);
      r_d_ack  <= (w_done || w_abort) && (r_state == DATA);
      r_err    <= w_abort;
      if ((w_done || w_abort) && (r_state == FETCH))
        r_if_rdata <= w_done ? mem_rdata : 32'h0;
      if ((w_done || w_abort) && (r_state == DATA))
        r_d_rdata <= (w_done && !r_we) ? mem_rdata : 32'h0;
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] r_perf;

  // Free-running count of stalled cycles, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_perf <= '0;
    else if (cpu_stall) r_perf <= r_perf + 32'd1;
  end

  assign perf_stall = r_perf;
`else
  assign perf_stall = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: table-driven and hand-written sequences with a
// scoreboard of expected acks, a memory responder model and a grant log.
module tb_cpu_mem_arbiter;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_req, if_ack, d_req, d_we, d_ack;
  logic        mem_req, mem_we, mem_ready, cpu_stall, err;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, perf_stall;

  cpu_mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .cpu_stall(cpu_stall), .err(err), .perf_stall(perf_stall)
  );

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          hang;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } grant_t;

  vec_t   fq[$], dq[$], exp_fq[$], exp_dq[$];
  grant_t glog[$];
  grant_t g_cur;
  vec_t   f_cur, d_cur;
  vec_t   tbl[10];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int mem_lat = 0;
  bit mem_hang = 0;
  bit ready_idle = 0;
  int mcnt = 0;
  bit f_act = 0, d_act = 0, f_acked = 0, d_acked = 0;
  int f_start = 0, d_start = 0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  function automatic vec_t mk(input bit is_data, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input bit hang,
                              input int exp_lat);
    vec_t v;
    v.is_data   = is_data;
    v.we        = we;
    v.addr      = addr;
    v.wdata     = wdata;
    v.lat       = lat;
    v.hang      = hang;
    v.exp_rdata = (hang || we) ? 32'h0 : memval(addr);
    v.exp_err   = hang;
    v.exp_lat   = exp_lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: memory responder and requesters update after the edge, monitor at negedge.
  task automatic step();
    vec_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (mem_req) begin
      if (mcnt == 0) begin
        g_cur.we    = mem_we;
        g_cur.addr  = mem_addr;
        g_cur.wdata = mem_wdata;
      end
      if (!mem_hang && mcnt == mem_lat) begin
        mem_ready = 1'b1;
        mem_rdata = memval(mem_addr);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      mcnt++;
    end else begin
      if (mcnt > 0) begin
        g_cur.cycles = mcnt;
        glog.push_back(g_cur);
      end
      mcnt = 0;
      mem_ready = ready_idle;
      mem_rdata = $urandom;
    end
    if (f_act && f_acked) begin f_act = 0; if_req = 1'b0; end
    if (d_act && d_acked) begin d_act = 0; d_req = 1'b0; end
    f_acked = 0;
    d_acked = 0;
    if (!f_act && fq.size() > 0) begin
      f_cur = fq.pop_front();
      if_addr = f_cur.addr; if_req = 1'b1; f_act = 1; f_start = cyc;
      exp_fq.push_back(f_cur);
    end
    if (!d_act && dq.size() > 0) begin
      d_cur = dq.pop_front();
      d_addr = d_cur.addr; d_we = d_cur.we; d_wdata = d_cur.wdata;
      d_req = 1'b1; d_act = 1; d_start = cyc;
      exp_dq.push_back(d_cur);
    end
    @(negedge clk);
    if (if_ack) begin
      f_acked = 1;
      if (exp_fq.size() == 0) begin
        total++; bad++;
        $display("FAIL if_ack_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_fq.pop_front();
        chk("if_rdata", if_rdata, e.exp_rdata);
        chk("if_err", 32'(err), 32'(e.exp_err));
        if (e.exp_lat >= 0) chk("if_latency", cyc - f_start, e.exp_lat);
      end
    end
    if (d_ack) begin
      d_acked = 1;
      if (exp_dq.size() == 0) begin
        total++; bad++;
        $display("FAIL d_ack_unexpected: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = exp_dq.pop_front();
        chk("d_rdata", d_rdata, e.exp_rdata);
        chk("d_err", 32'(err), 32'(e.exp_err));
        if (e.exp_lat >= 0) chk("d_latency", cyc - d_start, e.exp_lat);
      end
    end
    if (!if_ack && !d_ack) chk("err_without_ack", 32'(err), 32'h0);
    chk("cpu_stall", 32'(cpu_stall), 32'((if_req & ~if_ack) | (d_req & ~d_ack)));
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (fq.size() == 0 && dq.size() == 0 && !f_act && !d_act &&
          exp_fq.size() == 0 && exp_dq.size() == 0 && !mem_req) begin
        ok = 1;
        break;
      end
    end
    chk("wait_idle_budget", 32'(ok), 32'h1);
  endtask

  task automatic wait_mem_req(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (mem_req) begin ok = 1; break; end
    end
    chk("wait_mem_req_budget", 32'(ok), 32'h1);
  endtask

  // Asynchronous reset pulse between edges; drops all requester/scoreboard state.
  task automatic mid_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_d_ack", 32'(d_ack), 32'h0);
    chk("rst_if_ack", 32'(if_ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_act = 0; d_act = 0; f_acked = 0; d_acked = 0; mcnt = 0;
    fq.delete(); dq.delete(); exp_fq.delete(); exp_dq.delete(); glog.delete();
    mem_hang = 0; mem_ready = 1'b0;
    @(posedge clk);
    #1 chk("rst_hold_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    grant_t g;
    vec_t   v;
    logic [31:0] exp_addr[6];

    rst = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    #1 rst = 1'b0;
    #1;
    chk("reset_if_ack", 32'(if_ack), 32'h0);
    chk("reset_d_ack", 32'(d_ack), 32'h0);
    chk("reset_mem_req", 32'(mem_req), 32'h0);
    chk("reset_mem_we", 32'(mem_we), 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);
    chk("reset_if_rdata", if_rdata, 32'h0);
    chk("reset_d_rdata", d_rdata, 32'h0);
    chk("reset_err", 32'(err), 32'h0);
    chk("reset_perf", perf_stall, 32'h0);
    chk("reset_cpu_stall", 32'(cpu_stall), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single accesses: {port, we, addr, wdata, mem latency, hang} -> {rdata, err, ack latency}.
    tbl[0] = mk(0, 0, 32'h0000_0100, 32'h0,         0, 0, 2);
    tbl[1] = mk(1, 0, 32'h0000_2000, 32'h0,         0, 0, 2);
    tbl[2] = mk(1, 1, 32'h0000_2004, 32'hCAFEF00D,  1, 0, 3);
    tbl[3] = mk(0, 0, 32'h0000_0104, 32'h0,         3, 0, 5);
    tbl[4] = mk(1, 0, 32'h0000_2008, 32'h0,         6, 0, 8);
    tbl[5] = mk(1, 0, 32'h0000_200C, 32'h0,         7, 0, 9);
    tbl[6] = mk(0, 0, 32'h0000_0108, 32'h0,         0, 1, TIMEOUT + 1);
    tbl[7] = mk(1, 1, 32'h0000_3000, 32'h12345678,  0, 1, TIMEOUT + 1);
    tbl[8] = mk(0, 0, 32'h0000_010C, 32'h0,         7, 0, 9);
    tbl[9] = mk(1, 0, 32'hFFFF_FFFC, 32'h0,         0, 0, 2);

    for (int i = 0; i < 10; i++) begin
      glog.delete();
      mem_lat  = tbl[i].lat;
      mem_hang = tbl[i].hang;
      if (tbl[i].is_data) dq.push_back(tbl[i]);
      else                fq.push_back(tbl[i]);
      wait_idle(40);
      chk("tbl_grant_count", glog.size(), 32'd1);
      if (glog.size() > 0) begin
        g = glog.pop_front();
        chk("tbl_mem_addr", g.addr, tbl[i].addr);
        chk("tbl_mem_we", 32'(g.we), 32'(tbl[i].we));
        if (tbl[i].is_data) chk("tbl_mem_wdata", g.wdata, tbl[i].wdata);
        chk("tbl_mem_req_cycles", g.cycles, tbl[i].hang ? TIMEOUT : tbl[i].lat + 1);
      end
    end
    mem_hang = 0;
    mem_lat  = 0;

    // Starvation: fetch held while data re-requests; four data grants, then fetch.
    glog.delete();
    fq.push_back(mk(0, 0, 32'h0000_0400, 32'h0, 0, 0, -1));
    for (int i = 0; i < 5; i++) begin
      dq.push_back(mk(1, 0, 32'h0000_0500 + 32'(4 * i), 32'h0, 0, 0, (i == 0) ? 2 : -1));
      exp_addr[(i < 4) ? i : 5] = 32'h0000_0500 + 32'(4 * i);
    end
    exp_addr[4] = 32'h0000_0400;
    wait_idle(200);
    chk("starve_grant_count", glog.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (glog.size() > 0) begin
        g = glog.pop_front();
        chk("starve_grant_addr", g.addr, exp_addr[i]);
      end
    end

    // Simultaneous requests: data wins (starve cleared by the fetch grant), then fetch.
    glog.delete();
    fq.push_back(mk(0, 0, 32'h0000_0600, 32'h0, 0, 0, 5));
    dq.push_back(mk(1, 1, 32'h0000_0200, 32'h55, 0, 0, 2));
    wait_idle(40);
    chk("simul_grant_count", glog.size(), 32'd2);
    if (glog.size() == 2) begin
      g = glog.pop_front();
      chk("simul_first_we", 32'(g.we), 32'h1);
      chk("simul_first_addr", g.addr, 32'h0000_0200);
      chk("simul_first_wdata", g.wdata, 32'h55);
      g = glog.pop_front();
      chk("simul_second_addr", g.addr, 32'h0000_0600);
      chk("simul_second_we", 32'(g.we), 32'h0);
    end

    // Request dropped and inputs changed mid-access: original access completes.
    glog.delete();
    mem_lat = 3;
    dq.push_back(mk(1, 0, 32'h0000_0700, 32'h0, 3, 0, 5));
    wait_mem_req(10);
    d_req = 1'b0; d_addr = 32'h0000_07F0; d_we = 1'b1;
    wait_idle(40);
    if (glog.size() > 0) begin
      g = glog.pop_front();
      chk("drop_mem_addr", g.addr, 32'h0000_0700);
      chk("drop_mem_we", 32'(g.we), 32'h0);
    end else chk("drop_grant_count", glog.size(), 32'd1);
    mem_lat = 0;

    // mem_ready while idle is ignored.
    ready_idle = 1;
    for (int i = 0; i < 5; i++) step();
    chk("idle_ready_mem_req", 32'(mem_req), 32'h0);
    chk("idle_ready_grants", glog.size(), 32'd0);
    ready_idle = 0;
    step();

    // Asynchronous reset in the middle of a data access, then a normal access.
    mem_hang = 1;
    dq.push_back(mk(1, 0, 32'h0000_0800, 32'h0, 0, 1, -1));
    wait_mem_req(10);
    step();
    step();
    mid_reset();
    dq.push_back(mk(1, 0, 32'h0000_0804, 32'h0, 0, 0, 2));
    wait_idle(40);
    chk("post_rst_grants", glog.size(), 32'd1);

    // Stall-cycle counter: three one-cycle-latency accesses from reset.
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      v = mk(1, 0, 32'h0000_0900 + 32'(4 * i), 32'h0, 0, 0, 2);
      dq.push_back(v);
    end
    wait_idle(60);
    step();
    step();
`ifdef ARB_PERF_CNT_EN
    chk("perf_stall", perf_stall, 32'd6);
`else
    chk("perf_stall", perf_stall, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
